// File: rtl/alarm_timekeeper_if.sv
// Bus bundle for alarm_timekeeper.
// Inputs (master -> slave): debounced single-cycle pulses up/down/center/snooze and the
// alarm_en level. Outputs (slave -> master): registered time, alarm time, edit field,
// sec_tick and ring/snooze status.
interface alarm_timekeeper_if;
  logic       up_pulse;
  logic       down_pulse;
  logic       center_pulse;
  logic       snooze_pulse;
  logic       alarm_en;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic [2:0] edit_field;
  logic       sec_tick;
  logic       ringing;
  logic       snoozed;

  modport master (
    output up_pulse, down_pulse, center_pulse, snooze_pulse, alarm_en,
    input  hour, min, sec, alarm_hour, alarm_min, edit_field, sec_tick, ringing, snoozed
  );

  modport slave (
    input  up_pulse, down_pulse, center_pulse, snooze_pulse, alarm_en,
    output hour, min, sec, alarm_hour, alarm_min, edit_field, sec_tick, ringing, snoozed
  );
endinterface

// File: rtl/alarm_timekeeper.sv
// Timekeeping core: HH:MM:SS counters driven by a parametrised prescaler, a field-select
// set FSM, one alarm with snooze and an auto-timeout of the ring.
// Ports:
//   clk   - system clock
//   reset - asynchronous reset, active-high
//   bus   - alarm_timekeeper_if.slave: button pulses and alarm_en in; time, alarm time,
//           edit_field, sec_tick, ringing and snoozed out (all registered).
module alarm_timekeeper #(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned SNOOZE_MIN  = 5,
  parameter int unsigned RING_SEC    = 60,
  parameter int unsigned ALARM_RST_H = 7,
  parameter int unsigned ALARM_RST_M = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  alarm_timekeeper_if.slave    bus
);

  localparam int unsigned PreW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    StRun   = 3'd0,
    StSetH  = 3'd1,
    StSetM  = 3'd2,
    StSetS  = 3'd3,
    StSetAh = 3'd4,
    StSetAm = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic [PreW-1:0] pre_q, pre_d;
  logic [4:0]      hour_q, hour_d;
  logic [5:0]      min_q, min_d;
  logic [5:0]      sec_q, sec_d;
  logic [4:0]      alarm_h_q, alarm_h_d;
  logic [5:0]      alarm_m_q, alarm_m_d;
  logic [4:0]      snz_h_q, snz_h_d;
  logic [5:0]      snz_m_q, snz_m_d;
  logic [7:0]      ring_cnt_q, ring_cnt_d;
  logic            ringing_q, ringing_d;
  logic            snoozed_q, snoozed_d;
  logic            sec_tick_q;

  logic            counting;
  logic            tick;
  logic            edit_up;
  logic            edit_dn;
  logic            alarm_hit;
  logic            snooze_hit;
  logic [6:0]      snz_sum;

  // Simultaneous up and down cancel out.
  assign edit_up = bus.up_pulse & ~bus.down_pulse;
  assign edit_dn = bus.down_pulse & ~bus.up_pulse;

  // ---------------------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. A center press while ringing is consumed by the ring stop.
  always_comb begin
    state_d = state_q;
    if (bus.center_pulse && !ringing_q) begin
      unique case (state_q)
        StRun:   state_d = StSetH;
        StSetH:  state_d = StSetM;
        StSetM:  state_d = StSetS;
        StSetS:  state_d = StSetAh;
        StSetAh: state_d = StSetAm;
        StSetAm: state_d = StRun;
        default: state_d = StRun;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    bus.edit_field = state_q;
    bus.hour       = hour_q;
    bus.min        = min_q;
    bus.sec        = sec_q;
    bus.alarm_hour = alarm_h_q;
    bus.alarm_min  = alarm_m_q;
    bus.sec_tick   = sec_tick_q;
    bus.ringing    = ringing_q;
    bus.snoozed    = snoozed_q;
  end

  // ---------------------------------------------------------------------------------------
  // Prescaler: frozen at 0 while a time field is being edited.
  // ---------------------------------------------------------------------------------------
  always_comb begin
    counting = (state_q == StRun) || (state_q == StSetAh) || (state_q == StSetAm);
    tick     = 1'b0;
    pre_d    = '0;
    if (counting) begin
      if (pre_q == PreMax) begin
        tick = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Time and alarm registers: running carry plus per-field edits (edits never carry).
  // ---------------------------------------------------------------------------------------
  always_comb begin
    hour_d    = hour_q;
    min_d     = min_q;
    sec_d     = sec_q;
    alarm_h_d = alarm_h_q;
    alarm_m_d = alarm_m_q;

    if (tick) begin
      if (sec_q == 6'd59) begin
        sec_d = '0;
        if (min_q == 6'd59) begin
          min_d  = '0;
          hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end

    unique case (state_q)
      StSetH: begin
        if (edit_up) hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        if (edit_dn) hour_d = (hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1;
      end
      StSetM: begin
        if (edit_up) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        if (edit_dn) min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
      end
      StSetS: begin
        if (edit_up || edit_dn) sec_d = '0;
      end
      StSetAh: begin
        if (edit_up) alarm_h_d = (alarm_h_q == 5'd23) ? 5'd0 : alarm_h_q + 5'd1;
        if (edit_dn) alarm_h_d = (alarm_h_q == 5'd0) ? 5'd23 : alarm_h_q - 5'd1;
      end
      StSetAm: begin
        if (edit_up) alarm_m_d = (alarm_m_q == 6'd59) ? 6'd0 : alarm_m_q + 6'd1;
        if (edit_dn) alarm_m_d = (alarm_m_q == 6'd0) ? 6'd59 : alarm_m_q - 6'd1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------------------
  // Ring / snooze control
  // ---------------------------------------------------------------------------------------
  always_comb begin
    ringing_d  = ringing_q;
    snoozed_d  = snoozed_q;
    ring_cnt_d = ring_cnt_q;
    snz_h_d    = snz_h_q;
    snz_m_d    = snz_m_q;

    // Compare against the time that this tick is about to produce.
    alarm_hit  = tick && (sec_d == 6'd0) && (hour_d == alarm_h_q) && (min_d == alarm_m_q);
    snooze_hit = tick && snoozed_q && (sec_d == 6'd0) && (hour_d == snz_h_q) &&
                 (min_d == snz_m_q);

    // Snooze target = current hour:min + SNOOZE_MIN; at most one minute wrap is possible.
    snz_sum = {1'b0, min_q} + 7'(SNOOZE_MIN);

    if (!bus.alarm_en) begin
      ringing_d = 1'b0;
      snoozed_d = 1'b0;
    end else begin
      if (ringing_q && tick) begin
        ring_cnt_d = ring_cnt_q + 8'd1;
        if (ring_cnt_d == 8'(RING_SEC)) ringing_d = 1'b0;
      end

      if (ringing_q && bus.center_pulse) begin
        ringing_d = 1'b0;
        snoozed_d = 1'b0;
      end else if (ringing_q && bus.snooze_pulse) begin
        ringing_d = 1'b0;
        snoozed_d = 1'b1;
        if (snz_sum >= 7'd60) begin
          snz_m_d = 6'(snz_sum - 7'd60);
          snz_h_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end else begin
          snz_m_d = snz_sum[5:0];
          snz_h_d = hour_q;
        end
      end

      // A fresh trigger overrides a timeout landing on the same tick.
      if (alarm_hit || snooze_hit) begin
        ringing_d  = 1'b1;
        ring_cnt_d = '0;
        if (snooze_hit) snoozed_d = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q      <= '0;
      hour_q     <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      alarm_h_q  <= 5'(ALARM_RST_H);
      alarm_m_q  <= 6'(ALARM_RST_M);
      snz_h_q    <= '0;
      snz_m_q    <= '0;
      ring_cnt_q <= '0;
      ringing_q  <= 1'b0;
      snoozed_q  <= 1'b0;
      sec_tick_q <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      alarm_h_q  <= alarm_h_d;
      alarm_m_q  <= alarm_m_d;
      snz_h_q    <= snz_h_d;
      snz_m_q    <= snz_m_d;
      ring_cnt_q <= ring_cnt_d;
      ringing_q  <= ringing_d;
      snoozed_q  <= snoozed_d;
      sec_tick_q <= tick;
    end
  end

endmodule

// File: tb/tb_alarm_timekeeper.sv
module tb_alarm_timekeeper;

  localparam int TickDiv   = 4;
  localparam int SnoozeMin = 5;
  localparam int RingSec   = 3;
  localparam int RstH      = 7;
  localparam int RstM      = 0;

  logic clk;
  logic reset;
  alarm_timekeeper_if bus ();

  alarm_timekeeper #(
    .TICK_DIV    (TickDiv),
    .SNOOZE_MIN  (SnoozeMin),
    .RING_SEC    (RingSec),
    .ALARM_RST_H (RstH),
    .ALARM_RST_M (RstM)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: time as seconds of day, alarm/snooze as minutes of day.
  int m_t, m_pre, m_st, m_al, m_ring, m_snz, m_tgt, m_rcnt, m_tick;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_pre = 0; m_st = 0; m_al = RstH * 60 + RstM;
    m_ring = 0; m_snz = 0; m_tgt = 0; m_rcnt = 0; m_tick = 0;
  endtask

  task automatic check_all();
    check_eq("hour",       int'(bus.hour),       m_t / 3600);
    check_eq("min",        int'(bus.min),        (m_t / 60) % 60);
    check_eq("sec",        int'(bus.sec),        m_t % 60);
    check_eq("alarm_hour", int'(bus.alarm_hour), m_al / 60);
    check_eq("alarm_min",  int'(bus.alarm_min),  m_al % 60);
    check_eq("edit_field", int'(bus.edit_field), m_st);
    check_eq("sec_tick",   int'(bus.sec_tick),   m_tick);
    check_eq("ringing",    int'(bus.ringing),    m_ring);
    check_eq("snoozed",    int'(bus.snoozed),    m_snz);
  endtask

  // One clock with the given pulses; advances the model and checks every output.
  task automatic cyc(input bit u, input bit d, input bit c, input bit s);
    int tick, t_n, al_n, r, z, tg, rc, st_n, h, mi, sc, ah, am, hit, shit, en, step;
    bus.up_pulse = u; bus.down_pulse = d; bus.center_pulse = c; bus.snooze_pulse = s;
    en   = int'(bus.alarm_en);
    step = (u != d) ? (u ? 1 : -1) : 0;
    tick = ((m_st == 0 || m_st >= 4) && m_pre == TickDiv - 1) ? 1 : 0;
    t_n  = tick ? (m_t + 1) % 86400 : m_t;
    h = t_n / 3600; mi = (t_n / 60) % 60; sc = t_n % 60;
    ah = m_al / 60; am = m_al % 60;
    if (step != 0) begin
      case (m_st)
        1: h  = (h + step + 24) % 24;
        2: mi = (mi + step + 60) % 60;
        3: sc = 0;
        4: ah = (ah + step + 24) % 24;
        5: am = (am + step + 60) % 60;
        default: ;
      endcase
    end
    t_n  = h * 3600 + mi * 60 + sc;
    al_n = ah * 60 + am;
    hit  = (tick && en && sc == 0 && t_n / 60 == m_al) ? 1 : 0;
    shit = (tick && en && m_snz && sc == 0 && t_n / 60 == m_tgt) ? 1 : 0;
    r = m_ring; z = m_snz; tg = m_tgt; rc = m_rcnt;
    if (!en) begin
      r = 0; z = 0;
    end else begin
      if (m_ring && tick) begin
        rc++;
        if (rc >= RingSec) r = 0;
      end
      if (m_ring && c) begin
        r = 0; z = 0;
      end else if (m_ring && s) begin
        r = 0; z = 1; tg = (m_t / 60 + SnoozeMin) % 1440;
      end
      if (hit || shit) begin
        r = 1; rc = 0;
        if (shit) z = 0;
      end
    end
    st_n = (c && !m_ring) ? (m_st + 1) % 6 : m_st;
    @(posedge clk);
    #1;
    m_pre  = (m_st == 0 || m_st >= 4) ? (tick ? 0 : m_pre + 1) : 0;
    m_t = t_n; m_al = al_n; m_ring = r; m_snz = z; m_tgt = tg; m_rcnt = rc;
    m_st = st_n; m_tick = tick;
    check_all();
  endtask

  function automatic int field_val();
    case (m_st)
      1: return m_t / 3600;
      2: return (m_t / 60) % 60;
      4: return m_al / 60;
      5: return m_al % 60;
      default: return 0;
    endcase
  endfunction

  task automatic goto_state(input int s);
    for (int k = 0; k < 8 && m_st != s; k++) cyc(0, 0, 1, 0);
  endtask

  task automatic set_field(input int tgt);
    for (int k = 0; k < 70 && field_val() != tgt; k++) cyc(1, 0, 0, 0);
  endtask

  task automatic run_until(input int tgt, input int budget);
    for (int k = 0; k < budget && m_t != tgt; k++) cyc(0, 0, 0, 0);
    if (m_t != tgt) check_eq("run_until_bound", m_t, tgt);
  endtask

  task automatic set_time_hm(input int h, input int mi);
    goto_state(1); set_field(h);
    goto_state(2); set_field(mi);
    goto_state(3); cyc(1, 0, 0, 0);
    goto_state(0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_hour"}, int'(bus.hour), 0);
    check_eq({tag, "_min"},  int'(bus.min), 0);
    check_eq({tag, "_sec"},  int'(bus.sec), 0);
    check_eq({tag, "_ah"},   int'(bus.alarm_hour), RstH);
    check_eq({tag, "_am"},   int'(bus.alarm_min), RstM);
    check_eq({tag, "_ef"},   int'(bus.edit_field), 0);
    check_eq({tag, "_tick"}, int'(bus.sec_tick), 0);
    check_eq({tag, "_ring"}, int'(bus.ringing), 0);
    check_eq({tag, "_snz"},  int'(bus.snoozed), 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.up_pulse = 0; bus.down_pulse = 0; bus.center_pulse = 0; bus.snooze_pulse = 0;
    bus.alarm_en = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    reset = 1'b0;

    // Midnight rollover from 23:59:55.
    cyc(0, 0, 1, 0); cyc(0, 1, 0, 0);
    check_eq("set_h_down_wrap", int'(bus.hour), 23);
    cyc(0, 0, 1, 0); cyc(0, 1, 0, 0);
    check_eq("set_m_down_wrap", int'(bus.min), 59);
    goto_state(0);
    run_until(86395, 400);
    run_until(0, 40);
    check_eq("midnight_hour", int'(bus.hour), 0);
    check_eq("midnight_min", int'(bus.min), 0);
    check_eq("midnight_sec", int'(bus.sec), 0);

    // Field editing with time frozen; no carry between fields.
    cyc(0, 0, 1, 0); cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    for (int k = 0; k < 61; k++) cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    check_eq("edit_min", int'(bus.min), 1);
    check_eq("edit_hour_kept", int'(bus.hour), 23);
    check_eq("frozen_sec", int'(bus.sec), 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, 0);
    check_eq("back_to_run", int'(bus.edit_field), 0);

    // Alarm at 00:01, ring times out after RING_SEC ticks.
    goto_state(4); set_field(0);
    goto_state(5); set_field(1);
    goto_state(1); set_field(0);
    goto_state(2); set_field(0);
    goto_state(3); cyc(1, 0, 0, 0);
    bus.alarm_en = 1;
    goto_state(0);
    run_until(59, 400);
    run_until(60, 10);
    check_eq("alarm_ring", int'(bus.ringing), 1);
    run_until(62, 20);
    check_eq("ring_still_on", int'(bus.ringing), 1);
    run_until(63, 20);
    check_eq("ring_timeout", int'(bus.ringing), 0);

    // Snooze across midnight: 23:58 + 5 -> 00:03.
    goto_state(4); set_field(23);
    goto_state(5); set_field(58);
    goto_state(0);
    set_time_hm(23, 57);
    run_until(23 * 3600 + 58 * 60, 400);
    check_eq("alarm_2358", int'(bus.ringing), 1);
    cyc(0, 0, 0, 1);
    check_eq("snooze_ring_off", int'(bus.ringing), 0);
    check_eq("snooze_set", int'(bus.snoozed), 1);
    run_until(180, 2000);
    check_eq("snooze_ring", int'(bus.ringing), 1);
    check_eq("snooze_clr", int'(bus.snoozed), 0);

    // Center beats snooze in the same ringing cycle.
    cyc(0, 0, 1, 1);
    check_eq("prio_ring", int'(bus.ringing), 0);
    check_eq("prio_snz", int'(bus.snoozed), 0);
    check_eq("prio_state", int'(bus.edit_field), 0);

    // Ring while in SET_AM, then asynchronous reset mid-cycle.
    goto_state(4); set_field(0);
    goto_state(5); set_field(4);
    run_until(240, 400);
    check_eq("ring_in_set_am", int'(bus.ringing), 1);
    check_eq("state_set_am", int'(bus.edit_field), 5);
    bus.up_pulse = 0; bus.down_pulse = 0; bus.center_pulse = 0; bus.snooze_pulse = 0;
    #2 reset = 1'b1;
    #1 check_reset_vals("async");
    model_reset();
    #1 reset = 1'b0;

    // alarm_en low cancels a pending snooze for good.
    bus.alarm_en = 1;
    set_time_hm(6, 59);
    run_until(7 * 3600, 400);
    check_eq("alarm_0700", int'(bus.ringing), 1);
    cyc(0, 0, 0, 1);
    check_eq("snz_0700", int'(bus.snoozed), 1);
    bus.alarm_en = 0;
    cyc(0, 0, 0, 0);
    check_eq("en_low_snz", int'(bus.snoozed), 0);
    bus.alarm_en = 1;
    run_until(7 * 3600 + 5 * 60 + 10, 2000);
    check_eq("no_revive_ring", int'(bus.ringing), 0);
    check_eq("no_revive_snz", int'(bus.snoozed), 0);

    // Random pulses against the model, alarm placed a few minutes ahead.
    goto_state(5); set_field(8);
    goto_state(0);
    for (int k = 0; k < 4000; k++) begin
      bus.alarm_en = ($urandom_range(0, 63) != 0);
      cyc($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 47) == 0, $urandom_range(0, 7) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
